// File: rtl/tdm_demux_rx_if.sv
// rtl/tdm_demux_rx_if.sv - serial link input and recovered frame output bundle
interface tdm_demux_rx_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 8
);
  logic                      din_valid;
  logic                      din;
  logic                      sync;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic                      frame_done;
  logic                      frame_err;
  logic                      busy;
  logic [CNT_W-1:0]          frame_count;

  // Link side: drives serial bits, observes recovered frames
  modport master (
    output din_valid, din, sync,
    input  dout, frame_done, frame_err, busy, frame_count
  );

  // Receiver side
  modport slave (
    input  din_valid, din, sync,
    output dout, frame_done, frame_err, busy, frame_count
  );
endinterface

// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - TDM serial frame receiver, sync-aligned demux to parallel channels
module tdm_demux_rx #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 8
) (
  input logic            clock,
  input logic            reset,
  tdm_demux_rx_if.slave  bus
);
  localparam int N  = CHANNELS * WIDTH;
  localparam int CW = $clog2(N);

  typedef enum logic {HUNT, RECV} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [N-1:0]     dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     shifted;

  // Next-state: consume a bit only when din_valid, pulses default low
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    shifted = shreg_q;
    if (bus.din_valid) begin
      shifted = {shreg_q[N-2:0], bus.din};
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            shreg_d = {{(N-1){1'b0}}, bus.din};
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          if (bus.sync) begin
            // Early sync: drop the partial frame and restart on this bit
            err_d   = 1'b1;
            shreg_d = {{(N-1){1'b0}}, bus.din};
            cnt_d   = CW'(1);
          end else begin
            shreg_d = shifted;
            if (cnt_q == CW'(N-1)) begin
              dout_d  = shifted;
              done_d  = 1'b1;
              count_d = count_q + CNT_W'(1);
              cnt_d   = '0;
              state_d = HUNT;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      shreg_q <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Outputs decode registered state only
  always_comb begin
    bus.dout        = dout_q;
    bus.frame_done  = done_q;
    bus.frame_err   = err_q;
    bus.busy        = (state_q == RECV);
    bus.frame_count = count_q;
  end
endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb/tb_tdm_demux_rx.sv - directed self-checking bench for tdm_demux_rx
module tb_tdm_demux_rx;
  localparam int CH = 4;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int N  = CH * W;

  logic clock = 1'b0;
  logic reset = 1'b1;

  tdm_demux_rx_if #(.CHANNELS(CH), .WIDTH(W), .CNT_W(CW)) bus_if ();

  tdm_demux_rx #(.CHANNELS(CH), .WIDTH(W), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] data;
    bit          stall;
    bit          idle_after;
    logic [15:0] exp_dout;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pulses(input string name, input logic done, input logic err, input logic busy);
    check({name, "_done"}, {31'd0, bus_if.frame_done}, {31'd0, done});
    check({name, "_err"},  {31'd0, bus_if.frame_err},  {31'd0, err});
    check({name, "_busy"}, {31'd0, bus_if.busy},       {31'd0, busy});
  endtask

  task automatic step(input logic v, input logic d, input logic s);
    @(negedge clock);
    bus_if.din_valid = v;
    bus_if.din       = d;
    bus_if.sync      = s;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_if.din_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] data, input bit stall, input bit verbose);
    for (int i = 0; i < N; i++) begin
      if (stall && (i == 5 || i == 12)) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, g[0], 1'b1);
          if (verbose) pulses($sformatf("gap%0d_%0d", i, g), 1'b0, 1'b0, 1'b1);
        end
      end
      step(1'b1, data[N-1-i], i == 0);
      if (verbose) pulses($sformatf("bit%0d", i), i == N-1, 1'b0, i < N-1);
    end
  endtask

  initial begin
    logic [15:0] d;

    vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 16'hA5C3, 8'd1};
    vecs[1] = '{16'hA5C3, 1'b1, 1'b1, 16'hA5C3, 8'd2};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 8'd3};
    vecs[3] = '{16'h0001, 1'b0, 1'b1, 16'h0001, 8'd4};
    vecs[4] = '{16'h3C96, 1'b0, 1'b1, 16'h3C96, 8'd5};

    bus_if.din_valid = 1'b0;
    bus_if.din       = 1'b0;
    bus_if.sync      = 1'b0;

    // Reset state
    #2;
    check("rst_dout", {16'd0, bus_if.dout}, 32'd0);
    check("rst_count", {24'd0, bus_if.frame_count}, 32'd0);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Frame table: basic, stalled, back-to-back
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].stall, 1'b1);
      check($sformatf("vec%0d_dout", v), {16'd0, bus_if.dout}, {16'd0, vecs[v].exp_dout});
      check($sformatf("vec%0d_count", v), {24'd0, bus_if.frame_count}, {24'd0, vecs[v].exp_count});
      if (vecs[v].idle_after) begin
        step(1'b0, 1'b1, 1'b1);
        pulses($sformatf("vec%0d_idle", v), 1'b0, 1'b0, 1'b0);
        check($sformatf("vec%0d_hold", v), {16'd0, bus_if.dout}, {16'd0, vecs[v].exp_dout});
      end
    end

    // Hunting: unsynced bits are ignored, then back-to-back frames
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i[0], 1'b0);
      pulses($sformatf("hunt%0d", i), 1'b0, 1'b0, 1'b0);
    end
    check("hunt_dout", {16'd0, bus_if.dout}, 32'd0);
    check("hunt_count", {24'd0, bus_if.frame_count}, 32'd0);
    send_frame(16'hFFFF, 1'b0, 1'b1);
    send_frame(16'h0001, 1'b0, 1'b1);
    check("b2b_dout", {16'd0, bus_if.dout}, 32'h0001);
    check("b2b_count", {24'd0, bus_if.frame_count}, 32'd2);

    // Early sync aborts a partial frame
    do_reset();
    send_frame(16'hA5C3, 1'b0, 1'b0);
    d = 16'hBEEF;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, d[15-i], i == 0);
      pulses($sformatf("part%0d", i), 1'b0, 1'b0, 1'b1);
    end
    d = 16'h1234;
    step(1'b1, d[15], 1'b1);
    pulses("abort", 1'b0, 1'b1, 1'b1);
    check("abort_dout", {16'd0, bus_if.dout}, 32'hA5C3);
    check("abort_count", {24'd0, bus_if.frame_count}, 32'd1);
    for (int i = 1; i < N; i++) begin
      step(1'b1, d[15-i], 1'b0);
      pulses($sformatf("resync%0d", i), i == N-1, 1'b0, i < N-1);
      if (i == 1) check("abort_hold", {16'd0, bus_if.dout}, 32'hA5C3);
    end
    check("resync_dout", {16'd0, bus_if.dout}, 32'h1234);
    check("resync_count", {24'd0, bus_if.frame_count}, 32'd2);

    // Asynchronous reset mid-frame
    d = 16'hBEEF;
    for (int i = 0; i < 9; i++) step(1'b1, d[15-i], i == 0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_dout", {16'd0, bus_if.dout}, 32'd0);
    check("arst_count", {24'd0, bus_if.frame_count}, 32'd0);
    pulses("arst", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 9; i < N; i++) begin
      step(1'b1, d[15-i], 1'b0);
      pulses($sformatf("tail%0d", i), 1'b0, 1'b0, 1'b0);
    end
    check("tail_dout", {16'd0, bus_if.dout}, 32'd0);

    // Good-frame counter wrap
    do_reset();
    for (int f = 0; f < 256; f++) begin
      d = 16'(f * 16'h0101 + 16'h8000);
      send_frame(d, 1'b0, 1'b0);
      if (f == 254) check("wrap_255", {24'd0, bus_if.frame_count}, 32'd255);
      if (f == 255) begin
        check("wrap_0", {24'd0, bus_if.frame_count}, 32'd0);
        check("wrap_done", {31'd0, bus_if.frame_done}, 32'd1);
        check("wrap_dout", {16'd0, bus_if.dout}, 32'h7FFF);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
